td4_core: RTL
=============

TD4_CORE -- requirements
Module: td4_core

Interface
REQ-001 The block SHALL have parameter DW, default 4, giving the data and register width in bits (legal range 4..16).
REQ-002 The block SHALL have parameter AW, default 4, giving the program-counter and instruction-address width in bits (legal range 4..16).
REQ-003 The block SHALL have the port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have the port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have the port imem_req  output  1  instruction fetch request.
REQ-006 The block SHALL have the port imem_addr  output  AW  fetch address, equal to the PC.
REQ-007 The block SHALL have the port imem_ack  input  1  fetch acknowledge; imem_data is valid in the same cycle.
REQ-008 The block SHALL have the port imem_data  input  4+DW  instruction: [DW+3:DW] is the opcode, [DW-1:0] is the immediate (im).
REQ-009 The block SHALL have the port in_port  input  DW  input port sampled by the IN instructions.
REQ-010 The block SHALL have the port out_port  output  DW  registered output port.
REQ-011 The block SHALL have the port out_strobe  output  1  one-cycle pulse in the cycle after out_port is written.
REQ-012 The block SHALL have the port halted  output  1  high while the core is in state HALT.

Function
REQ-013 The block SHALL be a three-state FSM: FETCH, EXEC and HALT.
- FETCH: imem_req=1 with imem_addr=PC held stable. On the edge where imem_ack=1, capture imem_data into the instruction register (IR) and go to EXEC. Otherwise stay in FETCH.
- EXEC: imem_req=0. Commit the instruction on the next edge, then go to FETCH, or to HALT for opcode HALT.
REQ-014 An imem_ack arriving outside FETCH SHALL be ignored. With a zero-wait memory, each instruction SHALL take exactly 2 cycles.
REQ-015 The opcodes SHALL be as follows (all arithmetic is DW bits):
- 0000 A=A+im
- 0001 A=B
- 0010 A=in_port
- 0011 A=im
- 0100 B=A
- 0101 B=B+im
- 0110 B=in_port
- 0111 B=im
- 1001 OUT=B
- 1011 OUT=im
- 1110 JNC: PC=im if C=0
- 1111 JMP: PC=im
- 1101 HALT
- 1000, 1010, 1100 NOP
REQ-016 ADD opcodes SHALL set C to the carry-out of the DW-bit sum; the sum SHALL wrap modulo 2^DW.
REQ-017 Every other executed opcode, including JNC and JMP, SHALL clear C. JNC SHALL test C as it was before its own execution.
REQ-018 Jump targets SHALL be im[AW-1:0] when AW<=DW, and im zero-extended to AW bits when AW>DW.
REQ-019 A non-jump instruction, or a JNC not taken, SHALL set PC=PC+1, wrapping from 2^AW-1 to 0.
REQ-020 IN instructions SHALL sample in_port on the EXEC commit edge.
REQ-021 HALT SHALL leave the PC pointing at the HALT instruction. The core SHALL remain in HALT with imem_req=0 until reset. Register, PC and output values SHALL be frozen in HALT.
REQ-022 out_port SHALL change only on OUT instructions. out_strobe SHALL be high for exactly one cycle per OUT instruction, even when the value is unchanged.
REQ-023 The C flag SHALL be a flip-flop; no combinational feedback or latch is permitted.

Reset
REQ-024 While rst_n=0 at a clock edge, the next state SHALL be: A=0, B=0, PC=0, C=0, IR=0, out_port=0, out_strobe=0, state FETCH.
REQ-025 imem_req SHALL be 0 in the cycle after any edge where rst_n=0.
REQ-026 imem_req SHALL be 1, with imem_addr=0, in the first cycle after rst_n is sampled high.
REQ-027 Reset asserted mid-fetch or in EXEC SHALL abandon the instruction with no register, flag or port update. An imem_ack in that cycle SHALL be ignored.
REQ-028 Reset SHALL exit HALT.

Structure
REQ-029 Package td4_pkg SHALL hold the opcode constants and the FSM state enumerated type.
REQ-030 Sub-module td4_alu SHALL implement the parametrised DW-bit adder, with inputs a, b and outputs sum, cout. td4_core SHALL instantiate it once.
REQ-031 Only A, B, C, PC, IR, out_port, out_strobe and the FSM state SHALL be sequential.

Verification
REQ-032 The bench SHALL cover these directed scenarios (DW=4, AW=4, zero-wait memory unless stated):
- Program {0011_1110, 0000_0011, 1110_0101, ...}: A=14, then A=1 and C=1. The JNC is not taken, so the next imem_addr is 3 and C is cleared.
- Memory ack delayed 3 cycles: imem_req stays high with imem_addr stable for 4 cycles. No state changes before the ack.
- Program {0111_0101, 1001_0000, 1101_0000}: out_port=5 with one out_strobe pulse, then halted=1 and imem_req=0 for 20 cycles, with imem_addr=2.
- A 16-instruction program of NOPs: PC wraps 15 to 0; imem_addr sequence 0..15,0.
- rst_n=0 in the cycle of imem_ack for 0011_1010: A remains 0 and imem_req is 0 next cycle. After release, the fetch restarts at address 0.
- DW=8, AW=6: ADD 0xF0+0x20 gives A=0x10, C=1. JMP 0xFF targets 0x3F; in_port=0xA5 with IN A gives A=0xA5.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 core: opcode encodings and FSM state type.
package td4_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD_A   = 4'b0000;
    localparam logic [3:0] OP_MOV_AB  = 4'b0001;
    localparam logic [3:0] OP_IN_A    = 4'b0010;
    localparam logic [3:0] OP_MOV_AI  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA  = 4'b0100;
    localparam logic [3:0] OP_ADD_B   = 4'b0101;
    localparam logic [3:0] OP_IN_B    = 4'b0110;
    localparam logic [3:0] OP_MOV_BI  = 4'b0111;
    localparam logic [3:0] OP_OUT_B   = 4'b1001;
    localparam logic [3:0] OP_OUT_IM  = 4'b1011;
    localparam logic [3:0] OP_HALT    = 4'b1101;
    localparam logic [3:0] OP_JNC     = 4'b1110;
    localparam logic [3:0] OP_JMP     = 4'b1111;

endpackage

// File: rtl/td4_alu.sv
// DW-bit adder shared by both ADD opcodes; carry-out feeds the C flag.
module td4_alu #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/td4_core.sv
// TD4-style 4-bit-class CPU core: FETCH/EXEC/HALT sequencer with A, B, C, PC,
// registered output port and a single shared adder.
module td4_core
    import td4_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_ack,
    input  logic [DW+3:0]   imem_data,
    input  logic [DW-1:0]   in_port,
    output logic [DW-1:0]   out_port,
    output logic            out_strobe,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            c_q, c_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW+3:0]   ir_q, ir_d;
    logic [DW-1:0]   out_q, out_d;
    logic            strobe_q, strobe_d;
    // Low for the cycle following any reset edge so no fetch overlaps reset release.
    logic            req_en_q;

    logic [3:0]      opcode;
    logic [DW-1:0]   im;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_sum;
    logic            alu_cout;
    logic [AW-1:0]   jmp_tgt;
    logic [AW-1:0]   pc_inc;

    assign opcode = ir_q[DW+3:DW];
    assign im     = ir_q[DW-1:0];
    assign alu_a  = (opcode == OP_ADD_B) ? b_q : a_q;
    assign pc_inc = pc_q + AW'(1);

    generate
        if (AW <= DW) begin : g_tgt_narrow
            assign jmp_tgt = im[AW-1:0];
        end else begin : g_tgt_wide
            assign jmp_tgt = {{(AW-DW){1'b0}}, im};
        end
    endgenerate

    td4_alu #(
        .DW (DW)
    ) u_alu (
        .a    (alu_a),
        .b    (im),
        .sum  (alu_sum),
        .cout (alu_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        out_d    = out_q;
        strobe_d = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (req_en_q && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                c_d     = 1'b0;
                pc_d    = pc_inc;
                case (opcode)
                    OP_ADD_A: begin
                        a_d = alu_sum;
                        c_d = alu_cout;
                    end
                    OP_ADD_B: begin
                        b_d = alu_sum;
                        c_d = alu_cout;
                    end
                    OP_MOV_AB: a_d = b_q;
                    OP_IN_A:   a_d = in_port;
                    OP_MOV_AI: a_d = im;
                    OP_MOV_BA: b_d = a_q;
                    OP_IN_B:   b_d = in_port;
                    OP_MOV_BI: b_d = im;
                    OP_OUT_B: begin
                        out_d    = b_q;
                        strobe_d = 1'b1;
                    end
                    OP_OUT_IM: begin
                        out_d    = im;
                        strobe_d = 1'b1;
                    end
                    // JNC looks at the flag from before this instruction clears it.
                    OP_JNC: begin
                        if (!c_q) begin
                            pc_d = jmp_tgt;
                        end
                    end
                    OP_JMP:  pc_d = jmp_tgt;
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            pc_q     <= '0;
            ir_q     <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
            req_en_q <= 1'b1;
        end
    end

    assign imem_req   = (state_q == ST_FETCH) && req_en_q;
    assign imem_addr  = pc_q;
    assign out_port   = out_q;
    assign out_strobe = strobe_q;
    assign halted     = (state_q == ST_HALT);

endmodule
